// File: rtl/mpmc10_req_pipe.sv
// -----------------------------------------------------------------------------
// mpmc10_req_pipe
//
// Elastic valid/ready pipeline for mpmc10 request/response buses. Each stage
// is a 2-entry skid slice, so every ready is a flop output and one item per
// cycle is sustained under backpressure. Data is an opaque W-bit vector;
// callers cast their request/response structs to and from it.
//
// Parameters:
//   W      - data width in bits
//   STAGES - number of skid slices in series (0..8); 0 is a wire-through
//   LVLW   - width of the level output (derived from STAGES)
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   s_valid/s_ready/s_data - upstream handshake (s_ready registered)
//   m_valid/m_ready/m_data - downstream handshake (m_valid/m_data registered)
//   level              - registered count of entries held in all slices
//   flush              - synchronous discard of all entries; present only
//                        when MPMC10_PIPE_FLUSH_EN is defined
// -----------------------------------------------------------------------------
module mpmc10_req_pipe #(
    parameter int W      = 256,
    parameter int STAGES = 2,
    // A zero-stage build keeps a 1-bit level port tied low.
    parameter int LVLW   = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef MPMC10_PIPE_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [W-1:0]    m_data,
    output logic [LVLW-1:0] level
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } slice_state_e;

    logic w_flush;
`ifdef MPMC10_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    if (STAGES == 0) begin : g_bypass

        assign m_valid = s_valid;
        assign s_ready = m_ready;
        assign m_data  = s_data;
        assign level   = '0;

    end else begin : g_pipe

        // Cross-slice views: each slice publishes its registered outputs here.
        logic [STAGES-1:0] w_valid;
        logic [STAGES-1:0] w_rdy;
        logic [W-1:0]      w_data   [STAGES];
        logic [1:0]        w_cnt_nx [STAGES];
        logic [LVLW-1:0]   w_level_nx;
        logic [LVLW-1:0]   r_level;

        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            logic         r_main_v;
            logic         r_skid_v;
            logic         r_rdy;
            logic [W-1:0] r_main_d;
            logic [W-1:0] r_skid_d;

            logic         w_in_v;
            logic [W-1:0] w_in_d;
            logic         w_out_rdy;
            logic         w_acc;
            logic         w_take;
            logic         w_main_v_nx;
            logic         w_skid_v_nx;
            logic [W-1:0] w_main_d_nx;
            logic [W-1:0] w_skid_d_nx;
            slice_state_e w_state;

            if (k == 0) begin : g_head
                assign w_in_v = s_valid;
                assign w_in_d = s_data;
            end else begin : g_link
                assign w_in_v = w_valid[k-1];
                assign w_in_d = w_data[k-1];
            end

            if (k == STAGES - 1) begin : g_tail
                assign w_out_rdy = m_ready;
            end else begin : g_mid
                assign w_out_rdy = w_rdy[k+1];
            end

            assign w_acc   = w_in_v & r_rdy;
            assign w_take  = r_main_v & w_out_rdy;
            assign w_state = !r_main_v ? ST_EMPTY : (r_skid_v ? ST_TWO : ST_ONE);

            // NOTE: every output gets its hold value first, so no path through
            // the case leaves a signal unassigned and no latch is inferred.
            always_comb begin
                w_main_v_nx = r_main_v;
                w_skid_v_nx = r_skid_v;
                w_main_d_nx = r_main_d;
                w_skid_d_nx = r_skid_d;
                case (w_state)
                    ST_EMPTY: begin
                        if (w_acc) begin
                            w_main_v_nx = 1'b1;
                            w_main_d_nx = w_in_d;
                        end
                    end
                    ST_ONE: begin
                        if (w_acc && w_take) begin
                            w_main_d_nx = w_in_d;
                        end else if (w_acc) begin
                            // Downstream stalled: park the new item in the skid.
                            w_skid_v_nx = 1'b1;
                            w_skid_d_nx = w_in_d;
                        end else if (w_take) begin
                            w_main_v_nx = 1'b0;
                        end
                    end
                    ST_TWO: begin
                        // r_rdy is low here, so only the drain side can move.
                        if (w_take) begin
                            w_skid_v_nx = 1'b0;
                            w_main_d_nx = r_skid_d;
                        end
                    end
                    default: ;
                endcase
                // Flush wins over any same-cycle transfer, dropping it.
                if (w_flush) begin
                    w_main_v_nx = 1'b0;
                    w_skid_v_nx = 1'b0;
                end
            end

            // NOTE: sequential state uses non-blocking assignments so every
            // slice samples its neighbours' pre-edge values.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                    r_rdy    <= 1'b0;
                    // NOTE: the data registers are reset too, so m_data reads
                    // zero out of reset instead of stale contents.
                    r_main_d <= '0;
                    r_skid_d <= '0;
                end else begin
                    r_main_v <= w_main_v_nx;
                    r_skid_v <= w_skid_v_nx;
                    r_main_d <= w_main_d_nx;
                    r_skid_d <= w_skid_d_nx;
                    // Ready is computed from the next state so it is a pure flop.
                    r_rdy    <= !(w_main_v_nx && w_skid_v_nx);
                end
            end

            assign w_valid[k]  = r_main_v;
            assign w_rdy[k]    = r_rdy;
            assign w_data[k]   = r_main_d;
            assign w_cnt_nx[k] = {1'b0, w_main_v_nx} + {1'b0, w_skid_v_nx};
        end

        // Level is summed from next-state valids so it moves on the same edge.
        always_comb begin
            w_level_nx = '0;
            for (int i = 0; i < STAGES; i++) begin
                w_level_nx = w_level_nx + LVLW'(w_cnt_nx[i]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_level <= '0;
            end else begin
                r_level <= w_level_nx;
            end
        end

        assign s_ready = w_rdy[0];
        assign m_valid = w_valid[STAGES-1];
        assign m_data  = w_data[STAGES-1];
        assign level   = r_level;

    end

endmodule
